fsk_rx_controller: RTL and testbench

- Sequences the 12-bit FSK/UART deserializer.
- Gates the raw receive line into the deserializer and arms it on a start bit.
- Runs a watchdog on missing frame strobes.
- Buffers completed 12-bit words in a small FIFO with a valid/ready interface to downstream logic.
- Sits between the FSK demodulator output line and the packet/consumer logic.

---
 rtl/fsk_rx_controller.sv | 127 ++++++++++++
 tb/tb_fsk_rx_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_rx_controller.sv
// Gates the demodulated line into a 12-bit UART deserializer, arms on a start bit, watchdogs frame strobes and buffers words.
// Word visible on rx_word one cycle after des_status; a full FIFO drops the new word (sticky overflow) unless popped that cycle.
module fsk_rx_controller #(
  parameter int FRAME_W    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            rx_in,
  output logic                            des_rx,
  input  logic [FRAME_W-1:0]              des_data,
  input  logic                            des_status,
  output logic [FRAME_W-1:0]              rx_word,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            timeout_err,
  input  logic                            clear_err,
  output logic [15:0]                     frame_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARM, RECV} state_t;

  state_t              state;
  logic [WW-1:0]       watchdog;
  logic [FRAME_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;
  logic wd_expire;

  assign push      = des_status && (state == RECV);
  assign full      = (count == DEPTH_C);
  assign pop       = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot the new word lands in.
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign wd_expire = enable && (state == RECV) && !des_status && (watchdog == WD_LAST);

  assign des_rx     = (state == IDLE) ? 1'b1 : rx_in;
  assign rx_valid   = (count != '0);
  assign rx_word    = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      watchdog <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      watchdog <= '0;
    end else begin
      case (state)
        IDLE: state <= ARM;
        ARM: begin
          if (!rx_in) begin
            state    <= RECV;
            watchdog <= '0;
          end
        end
        RECV: begin
          if (des_status) begin
            watchdog <= '0;
          end else if (wd_expire) begin
            state    <= ARM;
            watchdog <= '0;
          end else begin
            watchdog <= watchdog + WW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          watchdog <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= des_data;
        wr_ptr      <= wr_ptr + AW'(1);
        frame_cnt   <= frame_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  // Setting event beats clear_err in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (clear_err) begin
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (drop)      overflow    <= 1'b1;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fsk_rx_controller.sv
// Directed bench for fsk_rx_controller: arming, buffering, overflow, watchdog, disable and async reset.
module tb_fsk_rx_controller;

  logic        clk = 1'b0;
  logic        rst_n, enable, rx_in, des_status, rx_ready, clear_err;
  logic [11:0] des_data;
  logic        des_rx, rx_valid, overflow, timeout_err;
  logic [11:0] rx_word;
  logic [2:0]  fifo_count;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fsk_rx_controller #(.FRAME_W(12), .FIFO_DEPTH(4), .TIMEOUT(256)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_in(rx_in), .des_rx(des_rx),
    .des_data(des_data), .des_status(des_status), .rx_word(rx_word),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_count(fifo_count),
    .overflow(overflow), .timeout_err(timeout_err), .clear_err(clear_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input logic [11:0] d);
    des_data   = d;
    des_status = 1'b1;
    tick();
    des_status = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; rx_in = 1'b0; des_status = 1'b0;
    rx_ready = 1'b0; clear_err = 1'b0; des_data = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (des_rx !== 1'b1)       begin n_fail++; $display("FAIL reset_des_rx got %b want 1", des_rx); end
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_word !== 12'h000)   begin n_fail++; $display("FAIL reset_rx_word got %h want 000", rx_word); end
    n_checks++; if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    n_checks++; if (frame_cnt !== 16'd0)   begin n_fail++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    #1;
    n_checks++; if (des_rx !== 1'b1)       begin n_fail++; $display("FAIL idle_forces_line got %b want 1", des_rx); end
  endtask

  task automatic test_arm_idle();
    rx_in = 1'b1; enable = 1'b1;
    repeat (50) tick();
    n_checks++; if (des_rx !== 1'b1)       begin n_fail++; $display("FAIL arm_des_rx got %b want 1", des_rx); end
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL arm_rx_valid got %b want 0", rx_valid); end
    strobe(12'h123);
    n_checks++; if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL arm_strobe_ignored got %0d want 0", fifo_count); end
    n_checks++; if (frame_cnt !== 16'd0)   begin n_fail++; $display("FAIL arm_frame_cnt got %0d want 0", frame_cnt); end
    rx_in = 1'b0;
    #1;
    n_checks++; if (des_rx !== 1'b0)       begin n_fail++; $display("FAIL arm_passes_line got %b want 0", des_rx); end
    tick();
    rx_in = 1'b1;
  endtask

  task automatic test_single_word();
    repeat (148) tick();
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL single_pre_valid got %b want 0", rx_valid); end
    strobe(12'hA5C);
    n_checks++; if (rx_valid !== 1'b1)     begin n_fail++; $display("FAIL single_valid got %b want 1", rx_valid); end
    n_checks++; if (rx_word !== 12'hA5C)   begin n_fail++; $display("FAIL single_word got %h want a5c", rx_word); end
    n_checks++; if (fifo_count !== 3'd1)   begin n_fail++; $display("FAIL single_count got %0d want 1", fifo_count); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL single_pop_valid got %b want 0", rx_valid); end
    n_checks++; if (frame_cnt !== 16'd1)   begin n_fail++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_overflow();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) strobe(12'(i));
    n_checks++; if (fifo_count !== 3'd4)   begin n_fail++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    n_checks++; if (overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_checks++; if (frame_cnt !== 16'd5)   begin n_fail++; $display("FAIL ovf_frame_cnt got %0d want 5", frame_cnt); end
    des_data = 12'h006; des_status = 1'b1; clear_err = 1'b1;
    tick();
    des_status = 1'b0; clear_err = 1'b0;
    n_checks++; if (overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_set_beats_clear got %b want 1", overflow); end
    n_checks++; if (frame_cnt !== 16'd5)   begin n_fail++; $display("FAIL ovf_drop_no_count got %0d want 5", frame_cnt); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (rx_word !== 12'(i))  begin n_fail++; $display("FAIL ovf_drain_%0d got %h want %h", i, rx_word, 12'(i)); end
      rx_ready = 1'b1;
      tick();
    end
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL ovf_drained_valid got %b want 0", rx_valid); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 7; i <= 10; i++) strobe(12'(i));
    n_checks++; if (fifo_count !== 3'd4)   begin n_fail++; $display("FAIL b2b_full got %0d want 4", fifo_count); end
    n_checks++; if (rx_word !== 12'h007)   begin n_fail++; $display("FAIL b2b_head got %h want 007", rx_word); end
    des_data = 12'h00B; des_status = 1'b1; rx_ready = 1'b1;
    tick();
    des_status = 1'b0; rx_ready = 1'b0;
    n_checks++; if (fifo_count !== 3'd4)   begin n_fail++; $display("FAIL b2b_count got %0d want 4", fifo_count); end
    n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    n_checks++; if (frame_cnt !== 16'd10)  begin n_fail++; $display("FAIL b2b_frame_cnt got %0d want 10", frame_cnt); end
    for (int i = 8; i <= 11; i++) begin
      n_checks++; if (rx_word !== 12'(i))  begin n_fail++; $display("FAIL b2b_drain_%0d got %h want %h", i, rx_word, 12'(i)); end
      rx_ready = 1'b1;
      tick();
    end
    rx_ready = 1'b0;
    n_checks++; if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL b2b_empty got %0d want 0", fifo_count); end
  endtask

  task automatic test_timeout();
    enable = 1'b0;
    tick();
    rx_in = 1'b0;
    #1;
    n_checks++; if (des_rx !== 1'b1)       begin n_fail++; $display("FAIL to_idle_line got %b want 1", des_rx); end
    enable = 1'b1; rx_in = 1'b1;
    tick();
    rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    repeat (255) tick();
    n_checks++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL to_early got %b want 0", timeout_err); end
    tick();
    n_checks++; if (timeout_err !== 1'b1)  begin n_fail++; $display("FAIL to_expire got %b want 1", timeout_err); end
    strobe(12'h3C3);
    n_checks++; if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL to_arm_ignore got %0d want 0", fifo_count); end
    n_checks++; if (frame_cnt !== 16'd10)  begin n_fail++; $display("FAIL to_arm_frame_cnt got %0d want 10", frame_cnt); end
    rx_in = 1'b0;
    #1;
    n_checks++; if (des_rx !== 1'b0)       begin n_fail++; $display("FAIL to_armed_line got %b want 0", des_rx); end
    rx_in = 1'b1;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL to_clear got %b want 0", timeout_err); end
  endtask

  task automatic test_disable_midframe();
    rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    strobe(12'hC01);
    strobe(12'hC02);
    n_checks++; if (fifo_count !== 3'd2)   begin n_fail++; $display("FAIL dis_count got %0d want 2", fifo_count); end
    enable = 1'b0; rx_in = 1'b0;
    tick();
    n_checks++; if (des_rx !== 1'b1)       begin n_fail++; $display("FAIL dis_line got %b want 1", des_rx); end
    strobe(12'hC03);
    n_checks++; if (fifo_count !== 3'd2)   begin n_fail++; $display("FAIL dis_idle_ignore got %0d want 2", fifo_count); end
    n_checks++; if (frame_cnt !== 16'd12)  begin n_fail++; $display("FAIL dis_frame_cnt got %0d want 12", frame_cnt); end
    n_checks++; if (rx_word !== 12'hC01)   begin n_fail++; $display("FAIL dis_drain0 got %h want c01", rx_word); end
    rx_ready = 1'b1;
    tick();
    n_checks++; if (rx_word !== 12'hC02)   begin n_fail++; $display("FAIL dis_drain1 got %h want c02", rx_word); end
    tick();
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL dis_drained got %b want 0", rx_valid); end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; rx_in = 1'b1;
    tick();
    rx_in = 1'b0;
    tick();
    strobe(12'hD11);
    n_checks++; if (fifo_count !== 3'd1)   begin n_fail++; $display("FAIL ar_pre_count got %0d want 1", fifo_count); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (fifo_count !== 3'd0)   begin n_fail++; $display("FAIL ar_count got %0d want 0", fifo_count); end
    n_checks++; if (rx_valid !== 1'b0)     begin n_fail++; $display("FAIL ar_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_word !== 12'h000)   begin n_fail++; $display("FAIL ar_word got %h want 000", rx_word); end
    n_checks++; if (frame_cnt !== 16'd0)   begin n_fail++; $display("FAIL ar_frame_cnt got %0d want 0", frame_cnt); end
    n_checks++; if (des_rx !== 1'b1)       begin n_fail++; $display("FAIL ar_line got %b want 1", des_rx); end
    n_checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0)
                                           begin n_fail++; $display("FAIL ar_flags got %b%b want 00", overflow, timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_arm_idle();
    test_single_word();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_disable_midframe();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL sim_time_limit got expired want finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
